// File: rtl/inst_loader.sv
// inst_loader: boot-time writer for the instruction memory.
//
// Takes a byte stream over a valid/ready handshake. The first byte of a load
// is a header N, the number of words that follow. The data bytes are packed
// into big-endian 32-bit words, and each word is written to the instruction
// RAM at byte address {count, 2'b00}, counting up from 0. The CPU is held in
// stall until a load completes successfully.
//
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Start                 pulse that begins a load (honoured in IDLE/DONE/ERR)
//   ByteIn, ByteValid     stream byte and its valid flag
//   ByteReady             loader can accept a byte; transfer = ByteValid & ByteReady
//   WrEn, WrAddr, WrData  one-cycle word write to the instruction RAM
//   WordCount             words written so far in the current load
//   Busy, Done, Err       status: load running / last load ok / bad header
//   CpuHold               CPU stall, low only in DONE
module inst_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [7:0]       ByteIn,
    input  logic             ByteValid,
    output logic             ByteReady,
    output logic             WrEn,
    output logic [31:0]      WrAddr,
    output logic [31:0]      WrData,
    output logic [CNT_W-1:0] WordCount,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic             CpuHold
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    state_t           state, nxt;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] n_words;
    logic [31:0]      word;
    logic             xfer;
    logic             hdr_bad;
    logic [CNT_W-1:0] count_inc;

    // ByteReady is a flop, so this AND never loops back into ByteReady.
    assign xfer      = ByteValid & ByteReady;
    assign hdr_bad   = (ByteIn == 8'd0) || ({1'b0, ByteIn} > DEPTH_B);
    assign count_inc = WordCount + CNT_W'(1);
    assign WrAddr    = 32'({WordCount, 2'b00});
    assign WrData    = word;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: if (Start) nxt = HDR;
            HDR:             if (xfer) nxt = hdr_bad ? ERR : DATA;
            DATA:            if (xfer && byte_idx == 2'd3) nxt = WRITE;
            WRITE:           nxt = (count_inc == n_words) ? DONE : DATA;
            default:         nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state, so each one is a
    // clean flop output that lines up with the state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            n_words   <= '0;
            word      <= 32'd0;
            WordCount <= '0;
            ByteReady <= 1'b0;
            WrEn      <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            CpuHold   <= 1'b1;
        end else begin
            state     <= nxt;
            ByteReady <= (nxt == HDR) || (nxt == DATA);
            WrEn      <= (nxt == WRITE);
            Busy      <= (nxt == HDR) || (nxt == DATA) || (nxt == WRITE);
            Done      <= (nxt == DONE);
            Err       <= (nxt == ERR);
            CpuHold   <= (nxt != DONE);
            case (state)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        WordCount <= '0;
                        byte_idx  <= 2'd0;
                    end
                end
                HDR: begin
                    // Only meaningful when the header is valid, which
                    // guarantees it fits in CNT_W bits.
                    if (xfer) n_words <= CNT_W'(ByteIn);
                end
                DATA: begin
                    // Shift left: the first byte ends up in [31:24].
                    if (xfer) begin
                        word     <= {word[23:0], ByteIn};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: WordCount <= count_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed bench for inst_loader. A scoreboard queue holds
// the expected writes. An entry is pushed when the last byte of a word is
// driven, and popped when WrEn is seen.
module tb_inst_loader;
    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             Start = 1'b0;
    logic [7:0]       ByteIn = 8'd0;
    logic             ByteValid = 1'b0;
    logic             ByteReady, WrEn, Busy, Done, Err, CpuHold;
    logic [31:0]      WrAddr, WrData;
    logic [CNT_W-1:0] WordCount;

    inst_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady), .WrEn(WrEn),
        .WrAddr(WrAddr), .WrData(WrData), .WordCount(WordCount),
        .Busy(Busy), .Done(Done), .Err(Err), .CpuHold(CpuHold)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t         sb[$];
    logic [31:0] wbuf [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every WrEn must match the oldest expected write.
    always @(negedge Clk) begin
        if (Rst_n && WrEn) begin
            wr_t e;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%h/%h expected=none", WrAddr, WrData);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", WrAddr, e.addr);
                chk("wr_data", WrData, e.data);
            end
        end
    end

    // Called and returns at a negedge. Holds the byte until a transfer occurs.
    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        ByteIn = b;
        ByteValid = 1'b1;
        while (!ByteReady && k < 50) begin
            @(negedge Clk);
            k++;
        end
        chk("byte_ready", 32'(ByteReady), 32'd1);
        if (ByteReady) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(Done || Err) && k < 200) begin
            @(negedge Clk);
            k++;
        end
        chk("end_timeout", 32'(Done || Err), 32'd1);
    endtask

    task automatic load_body(input int n, input bit toggle);
        send_byte(8'(n));
        if (toggle) begin ByteValid = 1'b0; @(negedge Clk); end
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 3) sb.push_back('{32'(w * 4), wbuf[w]});
                send_byte(wbuf[w][31 - 8 * b -: 8]);
                if (toggle) begin ByteValid = 1'b0; @(negedge Clk); end
            end
        end
        ByteValid = 1'b0;
        wait_end();
    endtask

    task automatic load(input int n, input bit toggle);
        pulse_start();
        load_body(n, toggle);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ByteReady), 32'd0);
        chk({tag, "_wren"},  32'(WrEn),      32'd0);
        chk({tag, "_addr"},  WrAddr,         32'd0);
        chk({tag, "_data"},  WrData,         32'd0);
        chk({tag, "_count"}, 32'(WordCount), 32'd0);
        chk({tag, "_busy"},  32'(Busy),      32'd0);
        chk({tag, "_done"},  32'(Done),      32'd0);
        chk({tag, "_err"},   32'(Err),       32'd0);
        chk({tag, "_hold"},  32'(CpuHold),   32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge Clk);
        chk_reset_vals("rst");
        Rst_n = 1'b1;
        @(negedge Clk);

        // Single word. The Start edge is load cycle 1, HDR is cycle 2, four
        // DATA cycles and one WRITE follow, and DONE is visible 6 edges after
        // the Start edge (2 + 5*1 = 7 cycles).
        pulse_start();
        start_cyc = cyc;
        chk("hdr_ready", 32'(ByteReady), 32'd1);
        chk("hdr_busy", 32'(Busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h01);
        send_byte(8'h00);
        sb.push_back('{32'h0, 32'h3C010003});
        send_byte(8'h03);
        ByteValid = 1'b0;
        chk("write_strobe", 32'(WrEn), 32'd1);
        chk("write_not_ready", 32'(ByteReady), 32'd0);
        @(negedge Clk);
        chk("single_done", 32'(Done), 32'd1);
        chk("single_hold", 32'(CpuHold), 32'd0);
        chk("single_latency", 32'(cyc - start_cyc), 32'd6);
        chk("single_count", 32'(WordCount), 32'd1);

        // Three words, ByteValid toggling.
        wbuf[0] = 32'h3402000C; wbuf[1] = 32'h00221820; wbuf[2] = 32'h00412022;
        load(3, 1'b1);
        chk("three_done", 32'(Done), 32'd1);
        chk("three_count", 32'(WordCount), 32'd3);
        chk("three_sb_empty", 32'(sb.size()), 32'd0);

        // Full depth.
        for (int k = 0; k < 32; k++) wbuf[k] = 32'(k);
        load(32, 1'b0);
        chk("full_done", 32'(Done), 32'd1);
        chk("full_count", 32'(WordCount), 32'd32);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);

        // Bad headers: 0, then DEPTH+1.
        pulse_start();
        send_byte(8'd0);
        ByteValid = 1'b0;
        chk("bad0_err", 32'(Err), 32'd1);
        chk("bad0_hold", 32'(CpuHold), 32'd1);
        chk("bad0_ready", 32'(ByteReady), 32'd0);
        chk("bad0_busy", 32'(Busy), 32'd0);
        pulse_start();
        send_byte(8'd33);
        ByteValid = 1'b0;
        chk("bad33_err", 32'(Err), 32'd1);
        chk("bad33_done", 32'(Done), 32'd0);
        chk("bad33_ready", 32'(ByteReady), 32'd0);
        repeat (3) @(negedge Clk);
        chk("bad33_stays", 32'(Err), 32'd1);
        wbuf[0] = 32'hAABBCCDD;
        load(1, 1'b0);
        chk("recover_err", 32'(Err), 32'd0);
        chk("recover_done", 32'(Done), 32'd1);

        // A Start during DATA is ignored.
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h11);
        Start = 1'b1;
        send_byte(8'h22);
        Start = 1'b0;
        send_byte(8'h33);
        sb.push_back('{32'h0, 32'h11223344});
        send_byte(8'h44);
        ByteValid = 1'b0;
        wait_end();
        chk("busy_start_done", 32'(Done), 32'd1);
        chk("busy_start_count", 32'(WordCount), 32'd1);

        // A Start in DONE begins a reload that overwrites word 0.
        pulse_start();
        chk("reload_hold", 32'(CpuHold), 32'd1);
        chk("reload_done", 32'(Done), 32'd0);
        chk("reload_count", 32'(WordCount), 32'd0);
        wbuf[0] = 32'hDEADBEEF;
        load_body(1, 1'b0);
        chk("reload_fin", 32'(Done), 32'd1);

        // Asynchronous reset in the middle of DATA.
        pulse_start();
        send_byte(8'd2);
        send_byte(8'h12);
        send_byte(8'h34);
        ByteValid = 1'b0;
        chk("mid_busy", 32'(Busy), 32'd1);
        #2 Rst_n = 1'b0;
        #1 chk_reset_vals("async");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_ready", 32'(ByteReady), 32'd0);
        chk("post_rst_busy", 32'(Busy), 32'd0);
        wbuf[0] = 32'hCAFEF00D;
        load(1, 1'b0);
        chk("post_rst_done", 32'(Done), 32'd1);

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues word writes to a writable instruction RAM at consecutive word-aligned byte addresses starting at 0. Holds the CPU in stall until a load completes. It is the write-side counterpart of the CPU's combinational `Inst = Mem[Addr>>2]` fetch port.

## Interface
- DEPTH, 32, number of instruction words in the target memory (max loadable count)
- CNT_W, 6, width of word counter (must hold DEPTH)
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- ByteIn  input  8  stream byte
- ByteValid  input  1  ByteIn is valid this cycle
- ByteReady  output  1  loader accepts ByteIn this cycle; a byte transfers when ByteValid & ByteReady
- WrEn  output  1  one-cycle instruction-memory write strobe
- WrAddr  output  32  byte address of the write, always word-aligned (`{count, 2'b00}`)
- WrData  output  32  assembled instruction word
- WordCount  output  CNT_W  words written so far in the current load
- Busy  output  1  load in progress (HDR, DATA or WRITE)
- Done  output  1  last load completed successfully
- Err  output  1  last load rejected (bad header)
- CpuHold  output  1  stall to CPU; high in every state except DONE

## Operation
- States: IDLE, HDR, DATA, WRITE, DONE, ERR.
- IDLE: ByteReady=0. Start -> HDR; clear WordCount, byte index, Done, Err.
- HDR: ByteReady=1. On transfer, latch N = ByteIn. N==0 or N>DEPTH -> ERR. Otherwise -> DATA.
- DATA: ByteReady=1. Each transfer shifts into the word register, MSB first: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0]. A 2-bit byte index increments per transfer; on the 4th transfer -> WRITE.
- WRITE: ByteReady=0. WrEn=1 for exactly this cycle; WrAddr = WordCount<<2; WrData = assembled word. WordCount increments at the end of the cycle. If new WordCount==N -> DONE, else -> DATA.
- DONE: Done=1, CpuHold=0. Start -> HDR (reload).
- ERR: Err=1, CpuHold=1. Start -> HDR.
- Start in HDR/DATA/WRITE is ignored.
- Bytes presented while ByteReady=0 are not consumed. The source must hold ByteIn and ByteValid stable until a transfer occurs.
- Memory contents outside words 0..N-1 are untouched.

## Timing
- Reset values: ByteReady=0, WrEn=0, WrAddr=0, WrData=0, WordCount=0, Busy=0, Done=0, Err=0, CpuHold=1, state=IDLE.
- Rst_n asserted mid-load aborts immediately to reset values. The partially written memory is not rolled back.
- All outputs are registered or decoded from the state register only. No combinational path exists from ByteValid to ByteReady.
- Start is sampled in cycle t; state is HDR and ByteReady=1 in cycle t+1.
- 4th data byte is accepted in cycle t; WrEn=1 in cycle t+1; ByteReady=1 again in cycle t+2.
- Peak throughput is 1 word per 5 cycles. Minimum load time from Start is 2 + 5N cycles to DONE.
- After the last WRITE, Done=1 and CpuHold=0 in the next cycle.
- ERR is entered the cycle after the bad header byte is accepted.
- WordCount wraps never: maximum value is DEPTH, equal to N.

## Test plan
- Reset: drive Rst_n=0 mid-DATA -> all outputs return to reset values within the same cycle (asynchronous), and the state is IDLE after release.
- Single word: Start, then bytes 01, 3C, 01, 00, 03 with continuous valid -> one WrEn with WrAddr=0 and WrData=32'h3C010003; Done=1 and CpuHold=0 at cycle 2+5=7 after Start.
- Three words with ByteValid toggling every other cycle: N=3, words 3402000C, 00221820, 00412022 -> writes at WrAddr 0, 4, 8 with those values, no dropped or duplicated bytes, WordCount ends at 3.
- Full depth: N=32, word k = k -> 32 writes, last at WrAddr=32'h7C; Done asserted; WordCount=32.
- Bad header: N=0, then in a separate run N=33 -> Err=1, CpuHold=1, no WrEn, ByteReady=0 in ERR; a subsequent Start plus a valid load -> Err clears and Done=1.
- Start while busy: pulse Start during DATA -> load continues unaffected. Start in DONE -> CpuHold rises the next cycle and a reload overwrites word 0.
